// File: rtl/adc_frame_packer.sv
// ADC block-average decimator and frame packer feeding an AXI-Stream-style master through a small FIFO.
// Build option: define AUTO_REARM_EN for continuous back-to-back frames after a single start.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; ad_valid ignored
// CAPTURE | accumulating samples, pushing decimated results into the FIFO
// DRAIN   | frame fully captured; emptying the FIFO until the tlast beat
module adc_frame_packer #(
   parameter int DATA_W     = 10,
   parameter int DECIM      = 8,
   parameter int FRAME_LEN  = 8192,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] ad_data,
   input  logic              ad_valid,
   input  logic              start,
   output logic [15:0]       m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow
);

   localparam int SH    = $clog2(DECIM);
   localparam int PH_W  = (SH > 0) ? SH : 1;
   localparam int ACC_W = DATA_W + SH;
   localparam int FC_W  = $clog2(FRAME_LEN);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int ENT_W = DATA_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];

   logic [ACC_W-1:0]  sum;
   logic [DATA_W-1:0] dec_val;
   logic [AW:0]       count;
   logic [ENT_W-1:0]  head;
   logic              dec_last, cap_fire, frame_last;
   logic              empty, full, pop, push;

   always_comb begin
      sum        = acc_q + ACC_W'(ad_data);
      dec_val    = DATA_W'(sum >> SH);
      dec_last   = (phase_q == PH_W'(DECIM - 1));
      cap_fire   = (state_q == S_CAPTURE) && ad_valid && dec_last;
      frame_last = (fcnt_q == FC_W'(FRAME_LEN - 1));
      count      = wr_ptr_q - rd_ptr_q;
      empty      = (wr_ptr_q == rd_ptr_q);
      full       = (count == (AW+1)'(FIFO_DEPTH));
      head       = mem_q[rd_ptr_q[AW-1:0]];
      pop        = !empty && m_tready;
      // a pop on the same edge frees the slot the push needs
      push       = cap_fire && (!full || pop);
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      phase_d  = phase_q;
      fcnt_d   = fcnt_q;
      ovf_d    = ovf_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      done_d   = pop && head[DATA_W];

      if (pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CAPTURE;
               acc_d   = '0;
               phase_d = '0;
               fcnt_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         S_CAPTURE: begin
            if (ad_valid) begin
               if (dec_last) begin
                  acc_d   = '0;
                  phase_d = '0;
               end else begin
                  acc_d   = sum;
                  phase_d = phase_q + PH_W'(1);
               end
            end
            if (cap_fire) begin
               if (push) begin
                  mem_d[wr_ptr_q[AW-1:0]] = {frame_last, dec_val};
                  wr_ptr_d = wr_ptr_q + (AW+1)'(1);
                  if (frame_last) begin
`ifdef AUTO_REARM_EN
                     fcnt_d = '0;
`else
                     state_d = S_DRAIN;
`endif
                  end else begin
                     fcnt_d = fcnt_q + FC_W'(1);
                  end
               end else begin
                  // dropped sample does not count toward the frame length
                  ovf_d = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (pop && head[DATA_W]) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         phase_q  <= '0;
         fcnt_q   <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         phase_q  <= phase_d;
         fcnt_q   <= fcnt_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_50m) begin
      mem_q <= mem_d;
   end

   assign m_tvalid   = !empty;
   assign m_tdata    = m_tvalid ? 16'(head[DATA_W-1:0]) : 16'd0;
   assign m_tlast    = m_tvalid && head[DATA_W];
   assign busy       = (state_q != S_IDLE);
   assign frame_done = done_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer with DECIM=4, FRAME_LEN=8, FIFO_DEPTH=4.
// Handshaken beats and frame_done pulses are logged on the falling edge; each task checks its own log.
module tb_adc_frame_packer;

   logic        clk_50m = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  ad_data = '0;
   logic        ad_valid = 1'b0;
   logic        start = 1'b0;
   logic        m_tready = 1'b1;
   logic [15:0] m_tdata;
   logic        m_tvalid, m_tlast, busy, frame_done, overflow;

   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   logic [15:0] q_data[$];
   logic        q_last[$];

   adc_frame_packer #(
      .DATA_W(10), .DECIM(4), .FRAME_LEN(8), .FIFO_DEPTH(4)
   ) dut (
      .clk_50m(clk_50m), .rst_n(rst_n), .ad_data(ad_data), .ad_valid(ad_valid),
      .start(start), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tlast(m_tlast), .busy(busy), .frame_done(frame_done), .overflow(overflow)
   );

   always #10 clk_50m = ~clk_50m;

   always @(negedge clk_50m) begin
      if (m_tvalid && m_tready) begin
         q_data.push_back(m_tdata);
         q_last.push_back(m_tlast);
      end
      if (frame_done) done_cnt++;
   end

   task automatic step;
      @(posedge clk_50m);
      #1;
   endtask

   task automatic clear_log;
      q_data.delete();
      q_last.delete();
      done_cnt = 0;
   endtask

   task automatic wait_frames(input int n);
      int k = 0;
      while (done_cnt < n && k < 100) begin
         step;
         k++;
      end
      repeat (3) step;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b1; ad_valid = 1'b1; ad_data = 10'd5; m_tready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step;
         checks++;
         if ({m_tdata, m_tvalid, m_tlast, busy, frame_done, overflow} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs cycle %0d: tdata=%0d tvalid=%b tlast=%b busy=%b done=%b ovf=%b, required all 0",
                     c, m_tdata, m_tvalid, m_tlast, busy, frame_done, overflow);
         end
      end
      rst_n = 1'b1; start = 1'b0;
      repeat (10) step;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_idle_busy: busy=%b, required 0", busy);
      end
      checks++;
      if (m_tvalid !== 1'b0) begin
         errors++; $display("FAIL reset_idle_tvalid: tvalid=%b, required 0", m_tvalid);
      end
      ad_valid = 1'b0;
   endtask

`ifndef AUTO_REARM_EN
   task automatic test_single_frame;
      clear_log;
      start = 1'b1; step; start = 1'b0;
      for (int i = 0; i < 32; i++) begin
         ad_data = 10'(i); ad_valid = 1'b1; step;
      end
      ad_valid = 1'b0;
      wait_frames(1);
      checks++;
      if (q_data.size() != 8) begin
         errors++; $display("FAIL single_beats: count=%0d, required 8", q_data.size());
      end
      for (int k = 0; k < 8 && k < q_data.size(); k++) begin
         checks++;
         if (q_data[k] !== 16'(4*k+1) || q_last[k] !== (k == 7)) begin
            errors++;
            $display("FAIL single_beat%0d: data=%0d last=%b, required data=%0d last=%b",
                     k, q_data[k], q_last[k], 4*k+1, (k == 7));
         end
      end
      checks++;
      if (done_cnt != 1 || busy !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL single_status: done=%0d busy=%b ovf=%b, required done=1 busy=0 ovf=0",
                  done_cnt, busy, overflow);
      end
   endtask

   task automatic test_backpressure;
      int exp_d[8] = '{1, 5, 9, 13, 21, 25, 29, 33};
      clear_log;
      start = 1'b1; step; start = 1'b0;
      for (int i = 0; i < 44; i++) begin
         ad_data = 10'(i); ad_valid = 1'b1; m_tready = (i >= 23); step;
      end
      ad_valid = 1'b0; m_tready = 1'b1;
      wait_frames(1);
      checks++;
      if (q_data.size() != 8) begin
         errors++; $display("FAIL bp_beats: count=%0d, required 8", q_data.size());
      end
      for (int k = 0; k < 8 && k < q_data.size(); k++) begin
         checks++;
         if (q_data[k] !== 16'(exp_d[k]) || q_last[k] !== (k == 7)) begin
            errors++;
            $display("FAIL bp_beat%0d: data=%0d last=%b, required data=%0d last=%b",
                     k, q_data[k], q_last[k], exp_d[k], (k == 7));
         end
      end
      checks++;
      if (overflow !== 1'b1 || done_cnt != 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_status: ovf=%b done=%0d busy=%b, required ovf=1 done=1 busy=0",
                  overflow, done_cnt, busy);
      end
   endtask

   task automatic test_full_scale;
      clear_log;
      start = 1'b1; step; start = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("FAIL fs_ovf_cleared: ovf=%b, required 0", overflow);
      end
      for (int i = 0; i < 64; i++) begin
         ad_data = 10'd1023; ad_valid = ((i % 2) == 0); step;
      end
      ad_valid = 1'b0;
      wait_frames(1);
      checks++;
      if (q_data.size() != 8) begin
         errors++; $display("FAIL fs_beats: count=%0d, required 8", q_data.size());
      end
      for (int k = 0; k < 8 && k < q_data.size(); k++) begin
         checks++;
         if (q_data[k] !== 16'd1023 || q_last[k] !== (k == 7)) begin
            errors++;
            $display("FAIL fs_beat%0d: data=%0d last=%b, required data=1023 last=%b",
                     k, q_data[k], q_last[k], (k == 7));
         end
      end
   endtask

   task automatic test_restart_and_reset;
      int i = 0;
      clear_log;
      start = 1'b1; step; start = 1'b0;
      while (q_data.size() < 3 && i < 32) begin
         ad_data = 10'(i); ad_valid = 1'b1; start = (i == 5); step;
         i++;
      end
      start = 1'b0; rst_n = 1'b0; step;
      checks++;
      if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || busy !== 1'b0 || m_tdata !== 16'd0) begin
         errors++;
         $display("FAIL midreset_outputs: tvalid=%b tlast=%b busy=%b tdata=%0d, required all 0",
                  m_tvalid, m_tlast, busy, m_tdata);
      end
      rst_n = 1'b1; ad_data = 10'd7;
      repeat (8) step;
      ad_valid = 1'b0;
      checks++;
      if (q_data.size() != 3 || done_cnt != 0) begin
         errors++;
         $display("FAIL midreset_beats: count=%0d done=%0d, required count=3 done=0", q_data.size(), done_cnt);
      end
      for (int k = 0; k < 3 && k < q_data.size(); k++) begin
         checks++;
         if (q_data[k] !== 16'(4*k+1) || q_last[k] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_beat%0d: data=%0d last=%b, required data=%0d last=0",
                     k, q_data[k], q_last[k], 4*k+1);
         end
      end
      clear_log;
      start = 1'b1; step; start = 1'b0;
      for (int j = 0; j < 32; j++) begin
         ad_data = 10'(j); ad_valid = 1'b1; step;
      end
      ad_valid = 1'b0;
      wait_frames(1);
      checks++;
      if (q_data.size() != 8 || done_cnt != 1) begin
         errors++;
         $display("FAIL fresh_frame: count=%0d done=%0d, required count=8 done=1", q_data.size(), done_cnt);
      end
      for (int k = 0; k < 8 && k < q_data.size(); k++) begin
         checks++;
         if (q_data[k] !== 16'(4*k+1) || q_last[k] !== (k == 7)) begin
            errors++;
            $display("FAIL fresh_beat%0d: data=%0d last=%b, required data=%0d last=%b",
                     k, q_data[k], q_last[k], 4*k+1, (k == 7));
         end
      end
   endtask
`else
   task automatic test_auto_rearm;
      clear_log;
      start = 1'b1; step; start = 1'b0;
      for (int i = 0; i < 64; i++) begin
         ad_data = 10'(i); ad_valid = 1'b1; step;
      end
      ad_valid = 1'b0;
      wait_frames(2);
      checks++;
      if (q_data.size() != 16 || done_cnt != 2) begin
         errors++;
         $display("FAIL auto_beats: count=%0d done=%0d, required count=16 done=2", q_data.size(), done_cnt);
      end
      for (int k = 0; k < 16 && k < q_data.size(); k++) begin
         checks++;
         if (q_data[k] !== 16'(4*k+1) || q_last[k] !== (k == 7 || k == 15)) begin
            errors++;
            $display("FAIL auto_beat%0d: data=%0d last=%b, required data=%0d last=%b",
                     k, q_data[k], q_last[k], 4*k+1, (k == 7 || k == 15));
         end
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL auto_busy: busy=%b, required 1", busy);
      end
   endtask
`endif

   initial begin
      test_reset;
`ifndef AUTO_REARM_EN
      test_single_frame;
      test_backpressure;
      test_full_scale;
      test_restart_and_reset;
`else
      test_auto_rearm;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
